// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle ALU plus an iterative multiply/divide
// engine that writes HI/LO. Results are registered and flagged by a one-cycle valid pulse.
module alu_mdu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state_q, state_d;

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;   // mul: upper accumulator / div: partial remainder
  logic [WIDTH-1:0] p_lo_q, p_lo_d;   // mul: multiplier shift reg / div: dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             run_step;
  logic             fix_step;
  logic             is_long;

  assign is_long = op[3] & op[2];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && is_long) state_d = S_RUN;
      S_RUN:   if (cnt_q == SHW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    accept   = start && (state_q == S_IDLE);
    run_step = (state_q == S_RUN);
    fix_step = (state_q == S_FIX);
  end

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] and_r, or_r, xor_r, nor_r;
  logic [WIDTH-1:0] alu_res;

  assign bb  = op[2] ? ~b : b;
  assign sum = a + bb + {{(WIDTH-1){1'b0}}, op[2]};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_r[gi] = a[gi] & bb[gi];
    assign or_r[gi]  = a[gi] | bb[gi];
    assign xor_r[gi] = a[gi] ^ b[gi];
    assign nor_r[gi] = ~(a[gi] | b[gi]);
  end

  always_comb begin
    alu_res = '0;
    if (!op[3]) begin
      case (op[1:0])
        2'b00:   alu_res = and_r;
        2'b01:   alu_res = or_r;
        2'b10:   alu_res = sum;
        default: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};  // raw sign, no overflow fix
      endcase
    end else begin
      case (op[1:0])
        2'b00:   alu_res = xor_r;
        2'b01:   alu_res = nor_r;
        2'b10:   alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
        default: alu_res = b << a[SHW-1:0];
      endcase
    end
  end

  // ---------------- mul/div datapath ----------------
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH+1:0] diff;
  logic             sub_ok;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign msum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Two spare bits so the borrow of the trial subtraction is unambiguous.
  assign diff   = {1'b0, p_hi_q, p_lo_q[WIDTH-1]} - {2'b00, opnd_q};
  assign sub_ok = ~diff[WIDTH+1];

  assign prod   = {p_hi_q, p_lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -p_lo_q : p_lo_q;
  assign rem    = neg_rem_q ? -p_hi_q : p_hi_q;

  always_comb begin
    cnt_d     = cnt_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    y_d       = y_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    valid_d   = 1'b0;

    if (accept && is_long) begin
      cnt_d     = '0;
      p_hi_d    = '0;
      p_lo_d    = a_mag;
      opnd_d    = b_mag;
      a_d       = a;
      is_div_d  = op[1];
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      divz_d    = (b == '0);
    end else if (accept) begin
      y_d     = alu_res;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end

    if (run_step) begin
      cnt_d = cnt_q + SHW'(1);
      if (is_div_q) begin
        p_hi_d = sub_ok ? diff[WIDTH-1:0] : {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
        p_lo_d = {p_lo_q[WIDTH-2:0], sub_ok};
      end else begin
        p_hi_d = msum[WIDTH:1];
        p_lo_d = {msum[0], p_lo_q[WIDTH-1:1]};
      end
    end

    if (fix_step) begin
      if (!is_div_q) begin
        hi_d = prod_s[2*WIDTH-1:WIDTH];
        lo_d = prod_s[WIDTH-1:0];
      end else if (divz_q) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
      y_d     = lo_d;
      zero_d  = (lo_d == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      y_q       <= '0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      y_q       <= y_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
    end
  end

  assign y     = y_q;
  assign zero  = zero_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32): legacy/extended ALU ops, mul/div
// results and latency, mid-op start, reset abort and back-to-back issue.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] y, hi, lo;
  logic         zero, busy, valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .y(y), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .valid(valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with start low.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ey, input logic ez);
    issue(o, av, bv);
    check({tag, "/valid"}, valid, 1);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/y"}, y, ey);
    check({tag, "/zero"}, zero, ez);
    check({tag, "/hilo"}, {hi, lo}, {exp_hi, exp_lo});
    $display("%s: op=%b a=%h b=%h y=%h zero=%0d", tag, o, av, bv, y, zero);
  endtask

  task automatic run_long(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input bit inject,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    int bcnt;
    issue(o, av, bv);
    lat  = 1;
    bcnt = 0;
    while (!valid && lat < 100) begin
      if (busy) bcnt++;
      if (inject && lat == 5) begin
        start = 1'b1; op = 4'b0010; a = 1; b = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "/latency"}, lat, 34);
    check({tag, "/busy_cycles"}, bcnt, 33);
    check({tag, "/busy_at_valid"}, busy, 0);
    check({tag, "/hi"}, hi, eh);
    check({tag, "/lo"}, lo, el);
    check({tag, "/y"}, y, el);
    check({tag, "/zero"}, zero, (el == 0));
    exp_hi = eh;
    exp_lo = el;
    $display("%s: op=%b a=%h b=%h hi=%h lo=%h latency=%0d", tag, o, av, bv, hi, lo, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    check("reset/outs", {y, hi, lo}, '0);
    check("reset/flags", {zero, busy, valid}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // Legacy and extended single-cycle ops
    single("add",      4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);
    single("sub_zero", 4'b0110, 32'd7, 32'd7, 32'd0, 1'b1);
    single("and_nb",   4'b0100, 32'h0000F0F0, 32'h000000FF, 32'h0000F000, 1'b0);
    single("or_nb",    4'b0101, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
    single("slt_add",  4'b0011, 32'hFFFFFFFD, 32'd1, 32'd1, 1'b0);
    single("slt_sub",  4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    single("slt_ge",   4'b0111, 32'd5, 32'd3, 32'd0, 1'b1);
    single("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
    single("sltu_no",  4'b1010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
    single("sltu_yes", 4'b1010, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
    single("sll",      4'b1011, 32'd4, 32'd3, 32'd48, 1'b0);
    single("sll_mask", 4'b1011, 32'h21, 32'd1, 32'd2, 1'b0);
    single("xor",      4'b1000, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0);
    single("nor",      4'b1001, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);

    // Multiply / divide
    run_long("mult",       4'b1100, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_long("multu",      4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_long("div_neg_a",  4'b1110, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("div_neg_b",  4'b1110, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD);
    run_long("divu_zero",  4'b1111, 32'd7, 32'd0, 1'b0, 32'd7, 32'hFFFFFFFF);
    run_long("div_zero",   4'b1110, 32'hFFFFFFFB, 32'd0, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_long("divu",       4'b1111, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    run_long("div_zq",     4'b1110, 32'd0, 32'd5, 1'b0, 32'd0, 32'd0);
    run_long("div_minint", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000);

    // ADD issued in the DIV valid cycle completes next cycle; hi/lo preserved
    single("b2b_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);

    // Reset 10 cycles into a MULTU discards it
    issue(4'b1101, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    check("abort/busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort/outs", {y, hi, lo}, '0);
    check("abort/flags", {zero, busy, valid}, 3'b000);
    exp_hi = '0;
    exp_lo = '0;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid || busy) vcnt++;
    end
    check("abort/no_late_result", vcnt, 0);
    $display("abort: reset during MULTU, activity after reset=%0d", vcnt);
    single("post_abort_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);

    // Reset together with start drops the op
    reset = 1'b1; start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start/valid", valid, 0);
    check("rst_start/y", y, 0);
    @(negedge clk);
    check("rst_start/later", {valid, busy}, 2'b00);
    $display("rst_start: y=%h valid=%0d", y, valid);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
